uart_mem_ctrl: RTL

- Command sequencer between a UART receiver, a UART transmitter and a single-port synchronous memory.
- Consumes frames from the receiver (rx_data/rx_done/clr_rx_done), decodes read/write commands, drives the memory, and returns one response frame through the transmitter.
- Sits at top level beside the UART rx/tx pair, so a host can load and inspect memory over the serial line.

---
 rtl/uart_mem_ctrl.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/uart_mem_ctrl.sv
// ----------------------------------------------------------------------------
// uart_mem_ctrl
// Command sequencer between a UART receiver/transmitter pair and a
// single-port synchronous memory. A host sends a header frame. The MSB of the
// header selects write (1) or read (0), and the low MEM_AW bits carry the
// address. A write also needs a data frame. Every completed command returns
// exactly one response frame: ACK_CODE for a write, or the read data.
//
// Ports:
//   clk, rst      clock, asynchronous active-high reset
//   rx_data       received frame, valid while rx_done=1
//   rx_done       receiver holds a frame
//   clr_rx_done   consume pulse back to the receiver (combinational)
//   tx_data       response frame, held stable from TX_LOAD to the exit of TX_WAIT
//   trmt          one-cycle transmit start (combinational on tx_busy)
//   tx_busy       transmitter is shifting
//   mem_addr      memory address
//   mem_wdata     memory write data
//   mem_we        one-cycle write strobe
//   mem_re        one-cycle read strobe; mem_rdata is valid the cycle after
//   mem_rdata     memory read data
//   busy          controller is not idle
//   err           one-cycle pulse when a write times out waiting for its data
//   cmd_cnt       completed-command counter, wraps at 2^16
// ----------------------------------------------------------------------------
module uart_mem_ctrl #(
    parameter int                    ADDR_WIDTH = 8,
    parameter int                    MEM_AW     = 4,
    parameter int                    TIMEOUT    = 65535,
    parameter logic [ADDR_WIDTH-1:0] ACK_CODE   = 8'h5A
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_WIDTH-1:0] rx_data,
    input  logic                  rx_done,
    output logic                  clr_rx_done,
    output logic [ADDR_WIDTH-1:0] tx_data,
    output logic                  trmt,
    input  logic                  tx_busy,
    output logic [MEM_AW-1:0]     mem_addr,
    output logic [ADDR_WIDTH-1:0] mem_wdata,
    output logic                  mem_we,
    output logic                  mem_re,
    input  logic [ADDR_WIDTH-1:0] mem_rdata,
    output logic                  busy,
    output logic                  err,
    output logic [15:0]           cmd_cnt
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_GET_DATA = 3'd1,
        S_WRITE    = 3'd2,
        S_MEM_RD   = 3'd3,
        S_MEM_WAIT = 3'd4,
        S_TX_LOAD  = 3'd5,
        S_TX_WAIT  = 3'd6
    } state_e;

    state_e                  state_q;
    logic [CNT_W-1:0]        tmo_q;
    logic                    guard_q;
    logic [MEM_AW-1:0]       mem_addr_q;
    logic [ADDR_WIDTH-1:0]   mem_wdata_q;
    logic [ADDR_WIDTH-1:0]   tx_data_q;
    logic [15:0]             cmd_cnt_q;
    logic                    mem_we_q;
    logic                    mem_re_q;

    // Sequencer state, timeout counter, datapath registers and memory strobes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            tmo_q       <= '0;
            guard_q     <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            tx_data_q   <= '0;
            cmd_cnt_q   <= 16'd0;
            mem_we_q    <= 1'b0;
            mem_re_q    <= 1'b0;
        end else begin
            // Strobes are set only on the transition into their state. This
            // keeps each strobe high for exactly the one cycle spent there.
            mem_we_q <= 1'b0;
            mem_re_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (rx_done) begin
                        mem_addr_q <= rx_data[MEM_AW-1:0];
                        if (rx_data[ADDR_WIDTH-1]) begin
                            tmo_q   <= CNT_W'(TIMEOUT);
                            state_q <= S_GET_DATA;
                        end else begin
                            mem_re_q <= 1'b1;
                            state_q  <= S_MEM_RD;
                        end
                    end
                end
                S_GET_DATA: begin
                    // A data frame arriving on the last counter value still wins.
                    if (rx_done) begin
                        mem_wdata_q <= rx_data;
                        mem_we_q    <= 1'b1;
                        state_q     <= S_WRITE;
                    end else if (tmo_q == '0) begin
                        state_q <= S_IDLE;
                    end else begin
                        tmo_q <= tmo_q - CNT_W'(1);
                    end
                end
                S_WRITE: begin
                    tx_data_q <= ACK_CODE;
                    state_q   <= S_TX_LOAD;
                end
                S_MEM_RD: begin
                    state_q <= S_MEM_WAIT;
                end
                S_MEM_WAIT: begin
                    tx_data_q <= mem_rdata;
                    state_q   <= S_TX_LOAD;
                end
                S_TX_LOAD: begin
                    if (!tx_busy) begin
                        guard_q <= 1'b1;
                        state_q <= S_TX_WAIT;
                    end
                end
                S_TX_WAIT: begin
                    // The transmitter may only raise tx_busy the cycle after
                    // trmt, so the first cycle here ignores tx_busy.
                    if (guard_q) begin
                        guard_q <= 1'b0;
                    end else if (!tx_busy) begin
                        cmd_cnt_q <= cmd_cnt_q + 16'd1;
                        state_q   <= S_IDLE;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    // Consume frames only where the FSM acts on them; gate with rst so the
    // receiver sees no consume while the controller is held in reset.
    assign clr_rx_done = !rst && rx_done &&
                         ((state_q == S_IDLE) || (state_q == S_GET_DATA));
    assign trmt        = (state_q == S_TX_LOAD) && !tx_busy;
    assign err         = (state_q == S_GET_DATA) && !rx_done && (tmo_q == '0);

    assign busy      = (state_q != S_IDLE);
    assign tx_data   = tx_data_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign mem_we    = mem_we_q;
    assign mem_re    = mem_re_q;
    assign cmd_cnt   = cmd_cnt_q;

endmodule
